fft_agu: RTL

- Address-generation and sequencing controller sitting directly upstream of the radix-2 butterfly unit in the in-place DIT FFT datapath.
- Steps through all L stages × N/2 butterflies and drives, each cycle, the operand read addresses for a ping-pong RAM pair and the twiddle ROM address.
- Drives latency-matched write-back addresses and enable so the butterfly's aout/bout return to the same indices in the other bank.
- Input data has already been loaded bit-reversed into bank 0 by the loader, using bit-reversal reindexing.

---
 rtl/fft_agu.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fft_agu.sv
// fft_agu: stage/butterfly sequencer and address generator for an in-place radix-2 DIT FFT
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-low
//   start        one-cycle request to begin a transform (sampled only in IDLE)
//   busy         high while reading or draining any stage
//   done         one-cycle pulse after the final write of the final stage
//   rd_en        read strobe for both operand ports of the read bank
//   rd_bank      bank being read (stage parity)
//   rd_adr_a/b   butterfly operand addresses
//   tw_adr       twiddle ROM index aligned with the read addresses
//   we           write strobe for both ports of the write bank
//   wr_bank      bank being written (read bank, delayed and inverted)
//   wr_adr_a/b   write-back addresses (read addresses delayed RD_LAT cycles)
//   result_bank  bank holding the finished spectrum
module fft_agu #(
    parameter int L      = 5,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         rd_en,
    output logic         rd_bank,
    output logic [L-1:0] rd_adr_a,
    output logic [L-1:0] rd_adr_b,
    output logic [L-2:0] tw_adr,
    output logic         we,
    output logic         wr_bank,
    output logic [L-1:0] wr_adr_a,
    output logic [L-1:0] wr_adr_b,
    output logic         result_bank
);
    localparam int SW = (L > 1) ? $clog2(L) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(L - 1);
    localparam logic [1:0]    C_LAST = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  s_q, s_d;
    logic [L-2:0]   i_q, i_d;
    logic [1:0]     c_q, c_d;
    logic [2*L-1:0] rot_a, rot_b;
    logic [2*L+1:0] dl_q [RD_LAT];
    logic [2*L+1:0] dl_d [RD_LAT];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        i_d     = i_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    i_d     = '0;
                end
            end
            RUN: begin
                i_d = i_q + (L-1)'(1);
                if (&i_q) begin
                    state_d = DRAIN;
                    c_d     = '0;
                end
            end
            DRAIN: begin
                c_d = c_q + 2'd1;
                if (c_q == C_LAST) begin
                    i_d     = '0;
                    state_d = (s_q == S_LAST) ? DONE : RUN;
                    s_d     = (s_q == S_LAST) ? s_q : s_q + SW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign done        = state_q == DONE;
    assign rd_en       = state_q == RUN;
    assign result_bank = 1'(L % 2);

    // Rotating the doubled word left by s leaves rotl(x, s) in the upper half.
    assign rot_a    = {2{i_q, 1'b0}} << s_q;
    assign rot_b    = {2{i_q, 1'b1}} << s_q;
    assign rd_bank  = rd_en & s_q[0];
    assign rd_adr_a = rd_en ? rot_a[2*L-1:L] : '0;
    assign rd_adr_b = rd_en ? rot_b[2*L-1:L] : '0;
    assign tw_adr   = rd_en ? (i_q & ({(L-1){1'b1}} << (S_LAST - s_q))) : '0;

    // The inverted bank is qualified by rd_en so an idle slot carries all zeros.
    always_comb begin
        dl_d[0] = {rd_en, rd_en & ~rd_bank, rd_adr_a, rd_adr_b};
        for (int k = 1; k < RD_LAT; k++) dl_d[k] = dl_q[k-1];
    end

    assign {we, wr_bank, wr_adr_a, wr_adr_b} = dl_q[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            i_q     <= '0;
            c_q     <= '0;
            for (int k = 0; k < RD_LAT; k++) dl_q[k] <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            i_q     <= i_d;
            c_q     <= c_d;
            dl_q    <= dl_d;
        end
    end
endmodule
